winner_policy_v2: RTL and testbench
===================================

# winner_policy_v2

Epsilon-greedy next-hop selector for the Q-learning routing datapath. On each `start` it chooses one of three results:
- this node itself, when it is the best sink;
- the greedy best candidate (exploit);
- a pseudo-random entry read from the neighbor table in shared memory (explore).

It sits between the Q-value/reward stage and the packet-forwarding logic. It reads memory through an address/read-data pair and never writes it.

## Interface
Parameters:
- `WORD_WIDTH`, 16, datapath and address width
- `NEIGHBOR_BASE`, 16'h0048, byte address of neighborID table (2-byte entries)
- `NEIGHBOR_IDX_BITS`, 6, neighbor index width (64 entries)
- `LFSR_SEED`, 16'hACE1, LFSR reset value (nonzero)

Ports:
- `clock`  in  1  single clock; all logic on rising edge
- `nreset`  in  1  reset, synchronous, active-high (asserted = 1, despite the name)
- `start`  in  1  level request, sampled in IDLE
- `mybest`  in  16  nonzero = this node is the best sink
- `besthop`  in  16  fallback next hop
- `bestvalue`  in  16  current best Q-value
- `better_qvalue`  in  16  best neighbor Q-value
- `bestneighborID`  in  16  ID of neighbor owning `better_qvalue`
- `MY_NODE_ID`  in  16  own node ID
- `address`  out  16  memory byte address (registered)
- `data_in`  in  16  memory read data, valid one cycle after `address`
- `epsilon`  in  16  exploration threshold
- `epsilon_step`  in  16  per-decision epsilon decrement
- `nexthop`  out  16  selected next hop (registered, held until next decision)
- `done`  out  1  one-cycle completion pulse
- `cstate`  out  8  current FSM state code, zero-extended

## Operation
- States: IDLE=0, DECIDE=1, FETCH=2, CAPTURE=3, DONE=4.
- IDLE:
  - With `start`=1, go to DECIDE.
  - On that transition, load `eps_cur` ← `epsilon` if `eps_loaded`=0, then set `eps_loaded`.
- DECIDE, priority order:
  - `mybest`≠0: `nexthop`←`MY_NODE_ID`, go to DONE.
  - Else if `lfsr` < `eps_cur` (unsigned): explore. `address`←`NEIGHBOR_BASE` + (`lfsr[NEIGHBOR_IDX_BITS-1:0]`<<1), go to FETCH.
  - Else exploit: `nexthop`←`bestneighborID` if `better_qvalue` > `bestvalue` (unsigned), otherwise `besthop`. Go to DONE.
- The LFSR advances exactly once per DECIDE cycle. The comparison and index use its pre-advance value.
- LFSR: 16-bit Fibonacci, shift right, new bit15 = b0^b2^b3^b5. `0xACE1` → `0x5670`.
- FETCH: wait for memory; go to CAPTURE.
- CAPTURE:
  - `nexthop`←`data_in`, except `data_in`==0 or ==`MY_NODE_ID` gives `bestneighborID`.
  - Go to DONE.
- DONE:
  - `done`=1 for this single cycle.
  - `address` returns to 0.
  - With decay enabled, `eps_cur` ← `eps_cur` − `epsilon_step`, saturating at 0.
  - Go to IDLE.
- `start` held high gives back-to-back decisions. `start` is ignored outside IDLE.

## Timing
- Reset values: `cstate`=0, `address`=0, `nexthop`=0, `done`=0, `lfsr`=`LFSR_SEED`, `eps_cur`=0, `eps_loaded`=0.
- Reset mid-operation aborts the decision and returns to IDLE on the next edge; no `done` is issued.
- Latency is counted from the edge that samples `start` in IDLE:
  - Exploit or mybest: `done` high after edge 2.
  - Explore: `done` high after edge 4.
- `nexthop` is valid in the same cycle `done` is high and stays stable until the next update.
- `address` is stable from DECIDE exit through CAPTURE.

## Configuration
- `WINNER_EPS_DECAY_EN` defined: `eps_cur` decays by `epsilon_step` each DONE (saturating at 0) and is loaded from `epsilon` only once after reset.
- `WINNER_EPS_DECAY_EN` undefined: no decay. `eps_cur` is reloaded from `epsilon` on every IDLE→DECIDE transition, and `epsilon_step` is ignored.

## Test plan
- Reset then `mybest`=1, `MY_NODE_ID`=7, `start`=1 → `cstate` 0→1→4, `done` pulses after edge 2, `nexthop`=7.
- Exploit:
  - `mybest`=0, `epsilon`=0, `better_qvalue`=3, `bestvalue`=2, `bestneighborID`=4 → `nexthop`=4, no FETCH.
  - Repeat with `bestvalue`=5, `besthop`=2 → `nexthop`=2.
- Explore: `epsilon`=0xFFFF, first run after reset (lfsr=0xACE1) → `address`=0x008A in FETCH; `data_in`=0x0012 in CAPTURE → `nexthop`=0x12, `done` after edge 4.
- Explore fallback: same as the explore case but `data_in`=`MY_NODE_ID`, or `data_in`=0 → `nexthop`=`bestneighborID`.
- Decay (macro on): `epsilon`=0xFFFF, `epsilon_step`=0x8000, `start` held high → explore, explore, then exploit once `eps_cur` saturates to 0. Macro off → explores on every run.
- Reset asserted while in FETCH → next cycle `cstate`=0, `address`=0, no `done`.

Source files
------------

// File: rtl/winner_policy_v2.sv
// Epsilon-greedy next-hop selector: self, greedy best neighbor, or a random neighbor-table entry.
// Optional macro WINNER_EPS_DECAY_EN: epsilon is loaded once after reset and decays on every decision.
module winner_policy_v2 #(
    parameter int                    WORD_WIDTH        = 16,
    parameter logic [WORD_WIDTH-1:0] NEIGHBOR_BASE     = 16'h0048,
    parameter int                    NEIGHBOR_IDX_BITS = 6,
    parameter logic [15:0]           LFSR_SEED         = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] mybest,
    input  logic [WORD_WIDTH-1:0] besthop,
    input  logic [WORD_WIDTH-1:0] bestvalue,
    input  logic [WORD_WIDTH-1:0] better_qvalue,
    input  logic [WORD_WIDTH-1:0] bestneighborID,
    input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
    output logic [WORD_WIDTH-1:0] address,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic [WORD_WIDTH-1:0] epsilon,
    input  logic [WORD_WIDTH-1:0] epsilon_step,
    output logic [WORD_WIDTH-1:0] nexthop,
    output logic                  done,
    output logic [7:0]            cstate
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DECIDE  = 3'd1,
        FETCH   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [15:0]             lfsr_r, lfsr_s;
    logic [WORD_WIDTH-1:0]   eps_cur_r, eps_cur_s;
    logic                    eps_loaded_r, eps_loaded_s;
    logic [WORD_WIDTH-1:0]   address_r, address_s;
    logic [WORD_WIDTH-1:0]   nexthop_r, nexthop_s;
    logic                    done_r, done_s;
    logic [WORD_WIDTH-1:0]   lfsr_ext_s;
    logic [WORD_WIDTH-1:0]   explore_addr_s;
    logic                    explore_s;

    // Fibonacci LFSR, shift right, taps at bits 0, 2, 3, 5
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

`ifndef WINNER_EPS_DECAY_EN
    logic unused_step_s;
    assign unused_step_s = ^epsilon_step;
`endif

    assign lfsr_ext_s     = WORD_WIDTH'(lfsr_r);
    assign explore_s      = (lfsr_ext_s < eps_cur_r);
    assign explore_addr_s = NEIGHBOR_BASE + WORD_WIDTH'({lfsr_r[NEIGHBOR_IDX_BITS-1:0], 1'b0});

    assign address = address_r;
    assign nexthop = nexthop_r;
    assign done    = done_r;
    assign cstate  = 8'(state_r);

    // Next-state and next-register-value logic
    always_comb begin
        state_s      = state_r;
        lfsr_s       = lfsr_r;
        eps_cur_s    = eps_cur_r;
        eps_loaded_s = eps_loaded_r;
        address_s    = address_r;
        nexthop_s    = nexthop_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s      = DECIDE;
                    eps_loaded_s = 1'b1;
`ifdef WINNER_EPS_DECAY_EN
                    if (!eps_loaded_r) begin
                        eps_cur_s = epsilon;
                    end else begin
                        eps_cur_s = eps_cur_r;
                    end
`else
                    eps_cur_s = epsilon;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            DECIDE: begin
                // Decision uses the pre-advance LFSR value
                lfsr_s = lfsr_next(lfsr_r);
                if (mybest != {WORD_WIDTH{1'b0}}) begin
                    nexthop_s = MY_NODE_ID;
                    state_s   = DONE;
                end else if (explore_s) begin
                    address_s = explore_addr_s;
                    state_s   = FETCH;
                end else begin
                    if (better_qvalue > bestvalue) begin
                        nexthop_s = bestneighborID;
                    end else begin
                        nexthop_s = besthop;
                    end
                    state_s = DONE;
                end
            end
            FETCH: begin
                state_s = CAPTURE;
            end
            CAPTURE: begin
                // Empty slot or a pointer back to ourselves is not a usable hop
                if ((data_in == {WORD_WIDTH{1'b0}}) || (data_in == MY_NODE_ID)) begin
                    nexthop_s = bestneighborID;
                end else begin
                    nexthop_s = data_in;
                end
                state_s = DONE;
            end
            DONE: begin
                address_s = {WORD_WIDTH{1'b0}};
`ifdef WINNER_EPS_DECAY_EN
                if (eps_cur_r > epsilon_step) begin
                    eps_cur_s = eps_cur_r - epsilon_step;
                end else begin
                    eps_cur_s = {WORD_WIDTH{1'b0}};
                end
`endif
                state_s = IDLE;
            end
            default: begin
                address_s = {WORD_WIDTH{1'b0}};
                state_s   = IDLE;
            end
        endcase
        done_s = (state_s == DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (nreset) begin
            state_r      <= IDLE;
            lfsr_r       <= LFSR_SEED;
            eps_cur_r    <= {WORD_WIDTH{1'b0}};
            eps_loaded_r <= 1'b0;
            address_r    <= {WORD_WIDTH{1'b0}};
            nexthop_r    <= {WORD_WIDTH{1'b0}};
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            lfsr_r       <= lfsr_s;
            eps_cur_r    <= eps_cur_s;
            eps_loaded_r <= eps_loaded_s;
            address_r    <= address_s;
            nexthop_r    <= nexthop_s;
            done_r       <= done_s;
        end
    end

endmodule

// File: tb/tb_winner_policy_v2.sv
// Directed bench for winner_policy_v2: vector table for single decisions plus
// hand sequences for back-to-back decay behaviour and reset during FETCH.
module tb_winner_policy_v2;

    logic        clock = 1'b0;
    logic        nreset;
    logic        start;
    logic [15:0] mybest, besthop, bestvalue, better_qvalue, bestneighborID, MY_NODE_ID;
    logic [15:0] address, data_in, epsilon, epsilon_step, nexthop;
    logic        done;
    logic [7:0]  cstate;

    logic        mem_force_en;
    logic [15:0] mem_force;

    int total  = 0;
    int passed = 0;

    always #5 clock = ~clock;

    // Memory model: one-cycle read latency
    always @(posedge clock) data_in <= mem_force_en ? mem_force : (address ^ 16'h5500);

    winner_policy_v2 dut (
        .clock(clock), .nreset(nreset), .start(start), .mybest(mybest),
        .besthop(besthop), .bestvalue(bestvalue), .better_qvalue(better_qvalue),
        .bestneighborID(bestneighborID), .MY_NODE_ID(MY_NODE_ID), .address(address),
        .data_in(data_in), .epsilon(epsilon), .epsilon_step(epsilon_step),
        .nexthop(nexthop), .done(done), .cstate(cstate)
    );

    typedef struct {
        logic [15:0] mybest;
        logic [15:0] epsilon;
        logic [15:0] better_q;
        logic [15:0] bestvalue;
        logic [15:0] mem;
        logic        explore;
        logic [15:0] exp_nexthop;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic do_reset();
        nreset = 1'b1;
        start  = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        nreset = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        int lat;
        logic [15:0] held;
        do_reset();
        mem_force_en  = 1'b1;
        mem_force     = vecs[idx].mem;
        mybest        = vecs[idx].mybest;
        epsilon       = vecs[idx].epsilon;
        better_qvalue = vecs[idx].better_q;
        bestvalue     = vecs[idx].bestvalue;
        start         = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk($sformatf("v%0d decide state", idx), 16'(cstate), 16'd1);
        chk($sformatf("v%0d done early", idx), 16'(done), 16'd0);
        lat = 0;
        for (int k = 2; k <= 8; k++) begin
            @(posedge clock);
            #1;
            if (k == 2 && vecs[idx].explore) begin
                chk($sformatf("v%0d fetch state", idx), 16'(cstate), 16'd2);
                chk($sformatf("v%0d fetch address", idx), address, 16'h008A);
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        chk($sformatf("v%0d latency", idx), 16'(lat), vecs[idx].explore ? 16'd4 : 16'd2);
        chk($sformatf("v%0d nexthop", idx), nexthop, vecs[idx].exp_nexthop);
        held = nexthop;
        @(posedge clock);
        #1;
        chk($sformatf("v%0d done pulse width", idx), 16'(done), 16'd0);
        chk($sformatf("v%0d back to idle", idx), 16'(cstate), 16'd0);
        chk($sformatf("v%0d address cleared", idx), address, 16'h0000);
        chk($sformatf("v%0d nexthop held", idx), nexthop, held);
    endtask

    initial begin
        int n_done, n_fetch, last_c, seen;
        logic [15:0] exp_nh[3];
        logic [15:0] exp_gap[3];
        logic [15:0] exp_addr[3];

        // mybest, epsilon, better_q, bestvalue, mem, explore, expected nexthop
        vecs[0]  = '{16'h0001, 16'h0000, 16'h0003, 16'h0002, 16'h0000, 1'b0, 16'h0007};
        vecs[1]  = '{16'h0000, 16'h0000, 16'h0003, 16'h0002, 16'h0000, 1'b0, 16'h0004};
        vecs[2]  = '{16'h0000, 16'h0000, 16'h0003, 16'h0005, 16'h0000, 1'b0, 16'h0002};
        vecs[3]  = '{16'h0000, 16'h0000, 16'h0005, 16'h0005, 16'h0000, 1'b0, 16'h0002};
        vecs[4]  = '{16'h0000, 16'h0000, 16'h8000, 16'h7FFF, 16'h0000, 1'b0, 16'h0004};
        vecs[5]  = '{16'h8000, 16'hFFFF, 16'h0003, 16'h0002, 16'h0012, 1'b0, 16'h0007};
        vecs[6]  = '{16'h0000, 16'hFFFF, 16'h0003, 16'h0002, 16'h0012, 1'b1, 16'h0012};
        vecs[7]  = '{16'h0000, 16'hFFFF, 16'h0003, 16'h0002, 16'h0007, 1'b1, 16'h0004};
        vecs[8]  = '{16'h0000, 16'hFFFF, 16'h0003, 16'h0002, 16'h0000, 1'b1, 16'h0004};
        vecs[9]  = '{16'h0000, 16'hACE1, 16'h0003, 16'h0002, 16'h0012, 1'b0, 16'h0004};
        vecs[10] = '{16'h0000, 16'hACE2, 16'h0003, 16'h0002, 16'h0033, 1'b1, 16'h0033};

        mybest = 16'h0; besthop = 16'h0002; bestvalue = 16'h0; better_qvalue = 16'h0;
        bestneighborID = 16'h0004; MY_NODE_ID = 16'h0007; epsilon = 16'h0;
        epsilon_step = 16'h8000; mem_force_en = 1'b1; mem_force = 16'h0;

        do_reset();
        nreset = 1'b1;
        @(posedge clock);
        #1;
        chk("reset cstate", 16'(cstate), 16'd0);
        chk("reset address", address, 16'h0000);
        chk("reset nexthop", nexthop, 16'h0000);
        chk("reset done", 16'(done), 16'd0);

        for (int i = 0; i < 11; i++) begin
            run_vec(i);
        end

        // Back-to-back decisions with start held high
        exp_nh[0]   = 16'h558A; exp_gap[0] = 16'd4; exp_addr[0] = 16'h008A;
        exp_nh[1]   = 16'h55A8; exp_gap[1] = 16'd5; exp_addr[1] = 16'h00A8;
        exp_addr[2] = 16'h00B8;
`ifdef WINNER_EPS_DECAY_EN
        exp_nh[2] = 16'h0004; exp_gap[2] = 16'd3;
`else
        exp_nh[2] = 16'h55B8; exp_gap[2] = 16'd5;
`endif
        do_reset();
        mem_force_en = 1'b0; mybest = 16'h0; epsilon = 16'hFFFF;
        better_qvalue = 16'h0003; bestvalue = 16'h0002;
        start = 1'b1;
        n_done = 0; n_fetch = 0; last_c = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            if (cstate == 8'd2 && n_fetch < 3) begin
                chk($sformatf("b2b fetch%0d address", n_fetch), address, exp_addr[n_fetch]);
                n_fetch++;
            end
            if (done) begin
                chk($sformatf("b2b run%0d nexthop", n_done), nexthop, exp_nh[n_done]);
                chk($sformatf("b2b run%0d interval", n_done), 16'(c - last_c), exp_gap[n_done]);
                last_c = c;
                n_done++;
                if (n_done == 3) break;
            end
        end
        start = 1'b0;
        chk("b2b decisions completed", 16'(n_done), 16'd3);

        // Reset while in FETCH aborts without done
        do_reset();
        mem_force_en = 1'b1; mem_force = 16'h0012; epsilon = 16'hFFFF;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        chk("abort in fetch", 16'(cstate), 16'd2);
        nreset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort cstate", 16'(cstate), 16'd0);
        chk("abort address", address, 16'h0000);
        chk("abort done", 16'(done), 16'd0);
        nreset = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            if (done) seen++;
        end
        chk("abort no late done", 16'(seen), 16'd0);
        chk("abort stays idle", 16'(cstate), 16'd0);
        chk("abort nexthop reset", nexthop, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
